// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//
// Instruction fetch controller for the multicycle CPU. Owns the program
// counter, presents it to the code memory as the read address, captures the
// registered instruction word the memory returns, and holds it in the
// instruction register for decode/execute. Multicycle instructions stall the
// fetch loop until execute reports completion; taken branches redirect the PC.
//
// Ports:
//   clock             in   system clock, rising edge
//   reset             in   asynchronous active-low reset
//   run               in   global run enable (also gates code memory); 0 freezes
//   curr_instruction  in   [16:0] registered code memory word ([16] = mc flag)
//   multicycle_flag   in   registered copy of curr_instruction[16]
//   exec_done         in   execute finished the current multicycle instruction
//   pc_load           in   branch taken: next PC comes from pc_target
//   pc_target         in   [5:0] branch destination
//   read_select       out  [5:0] code memory read address (= pc)
//   pc                out  [5:0] program counter
//   ir                out  [15:0] instruction register
//   ir_valid          out  one-cycle pulse, ir was updated
//   mc_busy           out  stalled on a multicycle instruction
//   state             out  [1:0] FSM state for debug
//   retired           out  [COUNT_W-1:0] completed-instruction count
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | out of reset, waiting for the first run cycle
// ISSUE   | pc presented on read_select, code memory samples it this edge
// CAPTURE | memory word valid; load ir, complete or enter STALL
// STALL   | multicycle instruction executing, wait for exec_done
// -----------------------------------------------------------------------------
module fetch_sequencer #(
  parameter logic [5:0] RESET_PC = 6'd0,
  parameter int         COUNT_W  = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               run,
  input  logic [16:0]        curr_instruction,
  input  logic               multicycle_flag,
  input  logic               exec_done,
  input  logic               pc_load,
  input  logic [5:0]         pc_target,
  output logic [5:0]         read_select,
  output logic [5:0]         pc,
  output logic [15:0]        ir,
  output logic               ir_valid,
  output logic               mc_busy,
  output logic [1:0]         state,
  output logic [COUNT_W-1:0] retired
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    STALL   = 2'd3
  } state_t;

  localparam logic [COUNT_W-1:0] RETIRE_STEP = COUNT_W'(1);

  state_t               state_q, state_d;
  logic [5:0]           pc_q, pc_d;
  logic [15:0]          ir_q, ir_d;
  logic                 ir_valid_q, ir_valid_d;
  logic                 mc_busy_q, mc_busy_d;
  logic [COUNT_W-1:0]   retired_q, retired_d;
  logic [5:0]           next_pc;
  logic                 complete;

  // The flag bit of the memory word is redundant with multicycle_flag, which
  // is the copy the stall decision is taken from.
  logic unused_word_flag;
  assign unused_word_flag = curr_instruction[16];

  // pc_load only matters on the completing edge; the mux is evaluated every
  // cycle but consumed only when complete is set.
  assign next_pc = pc_load ? pc_target : pc_q + 6'd1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      ir_q       <= 16'h0000;
      ir_valid_q <= 1'b0;
      mc_busy_q  <= 1'b0;
      retired_q  <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
      mc_busy_q  <= mc_busy_d;
      retired_q  <= retired_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    ir_valid_d = ir_valid_q;
    mc_busy_d  = mc_busy_q;
    retired_d  = retired_q;
    complete   = 1'b0;

    // With run low every register holds, including a pending ir_valid pulse,
    // so a pulse produced just before a freeze is still seen once on resume.
    if (run) begin
      ir_valid_d = 1'b0;
      unique case (state_q)
        IDLE:    state_d = ISSUE;
        ISSUE:   state_d = CAPTURE;
        CAPTURE: begin
          ir_d       = curr_instruction[15:0];
          ir_valid_d = 1'b1;
          if (multicycle_flag) begin
            mc_busy_d = 1'b1;
            state_d   = STALL;
          end else begin
            complete = 1'b1;
          end
        end
        STALL: begin
          if (exec_done) begin
            mc_busy_d = 1'b0;
            complete  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase

      if (complete) begin
        pc_d      = next_pc;
        retired_d = retired_q + RETIRE_STEP;
        state_d   = ISSUE;
      end
    end
  end

  assign read_select = pc_q;
  assign pc          = pc_q;
  assign ir          = ir_q;
  assign ir_valid    = ir_valid_q & run;
  assign mc_busy     = mc_busy_q;
  assign state       = state_q;
  assign retired     = retired_q;

  // The busy flag is a registered shadow of the STALL state.
  busy_matches_stall : assert property (
    @(posedge clock) disable iff (!reset) mc_busy_q == (state_q == STALL)
  );

endmodule

// File: tb/tb_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fetch_sequencer
//
// Drives fetch_sequencer with a behavioural code memory, directed scenarios
// and a randomized phase. An instruction-level reference model predicts PC,
// retirement count and the instruction stream; captured instructions are
// queued as they are predicted and popped by an independent monitor whenever
// the DUT raises ir_valid.
// -----------------------------------------------------------------------------
module tb_fetch_sequencer;

  localparam logic [5:0] RESET_PC = 6'd0;
  localparam int         COUNT_W  = 16;

  logic               clock = 1'b0;
  logic               reset = 1'b0;
  logic               run = 1'b0;
  logic [16:0]        curr_instruction = '0;
  logic               multicycle_flag = 1'b0;
  logic               exec_done = 1'b0;
  logic               pc_load = 1'b0;
  logic [5:0]         pc_target = '0;
  logic [5:0]         read_select;
  logic [5:0]         pc;
  logic [15:0]        ir;
  logic               ir_valid;
  logic               mc_busy;
  logic [1:0]         state;
  logic [COUNT_W-1:0] retired;

  always #5 clock = ~clock;

  fetch_sequencer #(.RESET_PC(RESET_PC), .COUNT_W(COUNT_W)) dut (
    .clock            (clock),
    .reset            (reset),
    .run              (run),
    .curr_instruction (curr_instruction),
    .multicycle_flag  (multicycle_flag),
    .exec_done        (exec_done),
    .pc_load          (pc_load),
    .pc_target        (pc_target),
    .read_select      (read_select),
    .pc               (pc),
    .ir               (ir),
    .ir_valid         (ir_valid),
    .mc_busy          (mc_busy),
    .state            (state),
    .retired          (retired)
  );

  // Code memory: registered read, gated by run like the real part.
  logic [16:0] mem [64];

  always @(posedge clock) begin
    if (!reset) begin
      curr_instruction <= '0;
      multicycle_flag  <= 1'b0;
    end else if (run) begin
      curr_instruction <= mem[read_select];
      multicycle_flag  <= mem[read_select][16];
    end
  end

  // ---------------------------------------------------------------------------
  // Reference model: tracks one instruction at a time.
  //   m_awake   : first run cycle after reset has passed
  //   m_fetched : address of the current instruction has been handed to memory
  //   m_busy    : current instruction is multicycle and still executing
  // ---------------------------------------------------------------------------
  int unsigned  vectors = 0;
  int unsigned  miscompares = 0;
  bit           checking = 1'b0;

  logic [5:0]   m_pc = RESET_PC;
  logic [15:0]  m_retired = '0;
  logic [15:0]  m_ir = '0;
  bit           m_awake = 1'b0;
  bit           m_fetched = 1'b0;
  bit           m_busy = 1'b0;
  bit           m_valid = 1'b0;
  logic [15:0]  exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_retire();
    if (pc_load) m_pc = pc_target;
    else         m_pc = 6'((int'(m_pc) + 1) % 64);
    m_retired = m_retired + 16'd1;
    m_fetched = 1'b0;
  endtask

  function automatic logic [1:0] m_state();
    if (!m_awake)      return 2'd0;
    else if (!m_fetched) return 2'd1;
    else if (m_busy)   return 2'd3;
    else               return 2'd2;
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_pc      = RESET_PC;
      m_retired = '0;
      m_ir      = '0;
      m_awake   = 1'b0;
      m_fetched = 1'b0;
      m_busy    = 1'b0;
      m_valid   = 1'b0;
      exp_q.delete();
    end else if (run) begin
      if (!m_awake) begin
        m_awake = 1'b1;
        m_valid = 1'b0;
      end else if (!m_fetched) begin
        m_fetched = 1'b1;
        m_valid   = 1'b0;
      end else if (!m_busy) begin
        m_ir    = mem[m_pc][15:0];
        m_valid = 1'b1;
        exp_q.push_back(m_ir);
        if (mem[m_pc][16]) m_busy = 1'b1;
        else               m_retire();
      end else begin
        m_valid = 1'b0;
        if (exec_done) begin
          m_busy = 1'b0;
          m_retire();
        end
      end
    end
  end

  // Monitor: per-cycle architectural state plus scoreboard pop on ir_valid.
  always @(negedge clock) begin
    if (checking) begin
      chk("pc", pc, m_pc);
      chk("read_select", read_select, m_pc);
      chk("retired", retired, m_retired);
      chk("mc_busy", mc_busy, m_busy);
      chk("state", state, m_state());
      chk("ir_valid", ir_valid, m_valid & run);
      chk("ir", ir, m_ir);
      if (ir_valid) begin
        if (exp_q.size() == 0) chk("scoreboard_underflow", 32'd1, 32'd0);
        else                   chk("ir_stream", ir, exp_q.pop_front());
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers: inputs change 1 time unit after the active edge.
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_capture(input string name, input int budget);
    int n = 0;
    while (!(m_awake && m_fetched && !m_busy) && n < budget) begin
      tick();
      n++;
    end
    chk(name, 32'(n < budget), 32'd1);
  endtask

  task automatic wait_stall(input string name, input int budget);
    int n = 0;
    while (!m_busy && n < budget) begin
      tick();
      n++;
    end
    chk(name, 32'(n < budget), 32'd1);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_pc"}, pc, RESET_PC);
    chk({tag, "_ir"}, ir, 16'h0000);
    chk({tag, "_ir_valid"}, ir_valid, 1'b0);
    chk({tag, "_mc_busy"}, mc_busy, 1'b0);
    chk({tag, "_retired"}, retired, '0);
    chk({tag, "_state"}, state, 2'd0);
  endtask

  initial begin
    int busy_cycles;
    int n;

    for (int i = 0; i < 64; i++) mem[i] = {1'b0, 16'(i)};
    mem[5]     = 17'h1_2345;
    mem[6'h2A] = {1'b0, 16'h0A2A};
    mem[63]    = {1'b0, 16'hBEEF};

    repeat (3) tick();
    checking = 1'b1;
    check_reset_values("reset");

    // Straight-line single-cycle fetches from RESET_PC.
    reset = 1'b1;
    run   = 1'b1;
    tick();
    chk("first_issue_state", state, 2'd1);
    chk("first_issue_rs", read_select, RESET_PC);
    n = 0;
    while (m_retired != 16'd3 && n < 20) begin
      tick();
      n++;
    end
    chk("retired_three", retired, 16'd3);

    // Multicycle instruction at address 5, completion after 4 stall cycles;
    // a branch pulse mid-stall without exec_done must be ignored.
    wait_stall("wait_mc", 20);
    chk("mc_ir", ir, 16'h2345);
    busy_cycles = 0;
    for (int k = 0; k < 4; k++) begin
      if (mc_busy) busy_cycles++;
      chk("stall_pc", pc, 6'd5);
      exec_done = (k == 3);
      pc_load   = (k == 1);
      pc_target = 6'h2A;
      tick();
    end
    exec_done = 1'b0;
    pc_load   = 1'b0;
    chk("busy_cycles", busy_cycles, 4);
    chk("mc_done_busy", mc_busy, 1'b0);
    chk("mc_done_pc", pc, 6'd6);

    // Branch taken from CAPTURE of a single-cycle instruction.
    wait_capture("wait_branch", 10);
    pc_load   = 1'b1;
    pc_target = 6'h2A;
    tick();
    pc_load = 1'b0;
    chk("branch_rs", read_select, 6'h2A);

    // PC wrap from 63.
    wait_capture("wait_to63", 10);
    pc_load   = 1'b1;
    pc_target = 6'd63;
    tick();
    pc_load = 1'b0;
    wait_capture("wait_at63", 10);
    tick();
    chk("wrap_rs", read_select, 6'd0);

    // Freeze for 3 cycles in STALL with exec_done held high.
    wait_capture("wait_to5", 10);
    pc_load   = 1'b1;
    pc_target = 6'd5;
    tick();
    pc_load = 1'b0;
    wait_stall("wait_freeze", 10);
    tick();
    run       = 1'b0;
    exec_done = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("freeze_ir_valid", ir_valid, 1'b0);
      chk("freeze_state", state, 2'd3);
      chk("freeze_pc", pc, 6'd5);
    end
    run = 1'b1;
    tick();
    exec_done = 1'b0;
    chk("resume_busy", mc_busy, 1'b0);
    chk("resume_pc", pc, 6'd6);

    // Asynchronous reset mid-CAPTURE.
    wait_capture("wait_rst_cap", 10);
    #2 reset = 1'b0;
    #1 check_reset_values("async_cap");
    tick();
    reset = 1'b1;
    tick();
    chk("post_rst_state", state, 2'd1);
    chk("post_rst_rs", read_select, RESET_PC);
    chk("post_rst_retired", retired, '0);

    // Asynchronous reset while stalled.
    wait_stall("wait_rst_stall", 20);
    #2 reset = 1'b0;
    #1 chk("async_stall_busy", mc_busy, 1'b0);
    chk("async_stall_state", state, 2'd0);

    // Randomized phase with a fresh memory image.
    for (int i = 0; i < 64; i++)
      mem[i] = {($urandom_range(3) == 0), 16'($urandom)};
    tick();
    reset = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      run       = ($urandom_range(9) != 0);
      exec_done = ($urandom_range(2) == 0);
      pc_load   = ($urandom_range(3) == 0);
      pc_target = 6'($urandom);
      if ($urandom_range(499) == 0) begin
        #2 reset = 1'b0;
        #1 check_reset_values("rand_async");
        tick();
        reset = 1'b1;
      end else begin
        tick();
      end
    end

    // Drain: let any held ir_valid pulse show, then confirm the queue is empty.
    run       = 1'b1;
    exec_done = 1'b0;
    pc_load   = 1'b0;
    repeat (2) tick();
    @(negedge clock);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
